esti_sample_sched: RTL
======================

// Module: esti_sample_sched
// PURPOSE
// Periodic scheduler between the I2C read driver and the estimator core. Issues one
// accelerometer read per sample period and collects the returned bytes. Removes the
// zero-g bias learned at start-up, then presents one signed 16-bit sample to esti_core
// with a single-cycle valid strobe. Replaces the direct end_flag-as-clock coupling.
// PARAMETERS
// SAMPLE_DIV   12000  clk cycles per sample period (1 kHz at 12 MHz); >= 16
// TIMEOUT_CYC  4096   max clk cycles in WAIT before the read is declared failed
// CAL_LOG2     4      2**CAL_LOG2 good samples are averaged for the bias
// PORTS
// clk        in   1   system clock
// reset      in   1   asynchronous, active-high reset
// enable     in   1   level; 1 = schedule reads
// recal      in   1   pulse; request re-calibration
// rd_req     out  1   read request to I2C driver; held until rd_ack
// rd_ack     in   1   driver accepted request (1-cycle pulse)
// rx_valid   in   1   rx_data carries a received byte this cycle
// rx_data    in   8   received byte, MSB-first order (byte0 = high, byte1 = low)
// rd_done    in   1   transaction complete (1-cycle pulse)
// rd_err     in   1   transaction failed/NACK (1-cycle pulse)
// acc_out    out  16  bias-corrected signed sample
// acc_valid  out  1   1-cycle strobe: acc_out is new
// cal_done   out  1   bias valid, samples being delivered
// err_cnt    out  8   failed reads (err, timeout, short read); saturates at 255
// ovr_cnt    out  8   sample ticks dropped while busy; saturates at 255
// BEHAVIOUR
// - Reset: state IDLE; rd_req=0, acc_out=0, acc_valid=0, cal_done=0, err_cnt=0,
//   ovr_cnt=0; tick counter, byte index, accumulator, bias and pending-recal all 0.
// - Tick counter: free-running 0..SAMPLE_DIV-1, wraps to 0; tick=1 when count==SAMPLE_DIV-1.
//   Runs regardless of enable.
// - FSM IDLE -> REQ -> WAIT -> PROC -> IDLE:
//   IDLE: tick & enable -> REQ (rd_req=1, byte index cleared).
//   REQ: rd_req held 1; rd_ack -> rd_req=0, WAIT next cycle. No timeout in REQ.
//   WAIT: rx_valid with idx 0 -> byte0; idx 1 -> byte1; idx saturates, extra bytes ignored.
//     rd_err -> IDLE, err_cnt++. rd_done with <2 bytes -> IDLE, err_cnt++.
//     rd_done with 2 bytes -> PROC. Wait counter == TIMEOUT_CYC-1 -> IDLE, err_cnt++.
//     rx_valid and rd_done in the same cycle: byte captured first, then count checked.
//     rd_err and rd_done in the same cycle: rd_err wins.
//   PROC: one cycle; sample s = {byte0,byte1} signed -> IDLE.
// - tick while state != IDLE: tick dropped (not queued), ovr_cnt++ saturating.
// - enable deasserted mid-transaction: current transaction completes normally;
//   no new REQ.
// - Calibration (cal_done=0): PROC adds sign-extended s into a (16+CAL_LOG2)-bit
//   accumulator; no acc_valid.
//   On the 2**CAL_LOG2-th good sample: bias = acc >>> CAL_LOG2 (arithmetic, truncating);
//   cal_done=1; accumulator and count cleared.
// - Run (cal_done=1): diff = s - bias in 17 bits; acc_out = diff saturated to
//   [-32768, 32767].
//   acc_valid=1 for exactly one cycle.
// - Latency: rd_done sampled at edge N -> PROC in cycle N..N+1 -> acc_out/acc_valid
//   visible after edge N+2.
// - recal pulse: sets pending flag; applied only on entry to IDLE (or immediately if in
//   IDLE): cal_done=0, accumulator/count cleared, bias kept until recomputed.
//   A recal during a transaction does not abort it. That sample is delivered under
//   the old bias.
// - Async reset mid-transaction: all state returns to reset values immediately; rd_req
//   drops to 0.
// TESTING
// 1 CAL_LOG2=2, samples 0x0010,0x0014,0x000C,0x0010 then 0x0015 -> no valid for first 4,
//   cal_done=1; then acc_out=0x0005, one acc_valid.
// 2 Bias 0x0100, sample 0x8000 -> acc_out=0x8000 (neg sat); bias 0xFFF0, sample 0x7FF8
//   -> acc_out=0x7FFF (pos sat).
// 3 rd_err with rd_done same cycle -> err_cnt=1, no acc_valid, FSM in IDLE;
//   rd_done after 1 byte -> err_cnt=2.
// 4 No rd_done for TIMEOUT_CYC cycles in WAIT -> IDLE, err_cnt+1; next tick issues rd_req.
// 5 SAMPLE_DIV=16, rd_ack held off 40 cycles -> ovr_cnt=2, exactly one read issued;
//   ovr_cnt stops at 255 on a long stall.
// 6 recal during WAIT -> sample delivered with old bias, then cal_done=0 and
//   4 samples re-averaged; reset asserted in WAIT -> rd_req=0, all counters 0.

Source files
------------

// File: rtl/esti_sample_sched.sv
// esti_sample_sched
// Periodic scheduler sitting between the I2C read driver and esti_core.
// Once per sample period it requests one accelerometer read, gathers the two
// returned bytes (MSB first), learns a zero-g bias from the first 2**CAL_LOG2
// good samples and then delivers bias-corrected, saturated signed samples with
// a single-cycle valid strobe.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   enable                level, 1 = schedule a read every sample period
//   recal                 pulse, request re-calibration of the bias
//   rd_req  / rd_ack      read request (held until ack) / driver accept pulse
//   rx_valid / rx_data    received byte strobe and data
//   rd_done / rd_err      transaction complete / failed pulses
//   acc_out / acc_valid   corrected sample and its 1-cycle strobe
//   cal_done              bias is valid and samples are being delivered
//   err_cnt / ovr_cnt     failed reads / dropped ticks, both saturating at 255
module esti_sample_sched #(
    parameter int SAMPLE_DIV  = 12000,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CAL_LOG2    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        recal,
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rd_done,
    input  logic        rd_err,
    output logic [15:0] acc_out,
    output logic        acc_valid,
    output logic        cal_done,
    output logic [7:0]  err_cnt,
    output logic [7:0]  ovr_cnt
);

    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int CW = CAL_LOG2 + 1;
    localparam int AW = 16 + CAL_LOG2;
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CAL_LAST  = CW'((1 << CAL_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PROC
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [7:0]           byte0_q, byte0_d;
    logic [7:0]           byte1_q, byte1_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [CW-1:0]        cal_cnt_q, cal_cnt_d;
    logic [15:0]          bias_q, bias_d;
    logic                 cal_done_q, cal_done_d;
    logic                 recal_pend_q, recal_pend_d;
    logic                 rd_req_q, rd_req_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic [7:0]           ovr_cnt_q, ovr_cnt_d;
    logic [15:0]          res_q, res_d;
    logic                 res_vld_q, res_vld_d;
    logic [15:0]          acc_out_q, acc_out_d;
    logic                 acc_valid_q, acc_valid_d;

    logic                 tick;
    logic                 err_inc;
    logic [1:0]           idx_n;
    logic [15:0]          sample;
    logic signed [AW-1:0] acc_sum;
    logic signed [16:0]   diff;
    logic [15:0]          diff_sat;

    assign tick    = (tick_cnt_q == TICK_LAST);
    assign sample  = {byte0_q, byte1_q};
    assign acc_sum = acc_q + AW'(signed'(sample));
    // 17 bits hold any difference of two 16-bit signed values, so the top two
    // bits tell us directly whether the result fits back into 16 bits.
    assign diff    = 17'(signed'(sample)) - 17'(signed'(bias_q));
    assign diff_sat = (diff[16:15] == 2'b01) ? 16'h7FFF :
                      (diff[16:15] == 2'b10) ? 16'h8000 : diff[15:0];

    // Next-state logic: tick counter, read FSM, calibration and output stage.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
        wait_cnt_d   = wait_cnt_q;
        idx_d        = idx_q;
        byte0_d      = byte0_q;
        byte1_d      = byte1_q;
        acc_d        = acc_q;
        cal_cnt_d    = cal_cnt_q;
        bias_d       = bias_q;
        cal_done_d   = cal_done_q;
        recal_pend_d = recal_pend_q | recal;
        rd_req_d     = rd_req_q;
        err_cnt_d    = err_cnt_q;
        ovr_cnt_d    = ovr_cnt_q;
        res_d        = res_q;
        res_vld_d    = 1'b0;
        acc_out_d    = acc_out_q;
        acc_valid_d  = res_vld_q;
        err_inc      = 1'b0;
        idx_n        = idx_q;

        // Result is registered once more so it appears two edges after rd_done.
        if (res_vld_q) begin
            acc_out_d = res_q;
        end

        // Ticks are never queued: a tick that finds a read in flight is lost.
        if (tick && (state_q != S_IDLE) && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end

        // A pending recal only takes effect once no transaction is in flight,
        // so the sample already being read still goes out with the old bias.
        if ((state_q == S_IDLE) && recal_pend_d) begin
            cal_done_d   = 1'b0;
            acc_d        = '0;
            cal_cnt_d    = '0;
            recal_pend_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (tick && enable) begin
                    state_d  = S_REQ;
                    rd_req_d = 1'b1;
                    idx_d    = '0;
                end
            end
            S_REQ: begin
                if (rd_ack) begin
                    rd_req_d   = 1'b0;
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // Capture first so a byte arriving with rd_done still counts.
                if (rx_valid) begin
                    if (idx_q == 2'd0) begin
                        byte0_d = rx_data;
                    end else if (idx_q == 2'd1) begin
                        byte1_d = rx_data;
                    end
                    if (idx_q != 2'd2) begin
                        idx_n = idx_q + 2'd1;
                    end
                end
                idx_d = idx_n;
                if (rd_err) begin
                    state_d = S_IDLE;
                    err_inc = 1'b1;
                end else if (rd_done) begin
                    if (idx_n == 2'd2) begin
                        state_d = S_PROC;
                    end else begin
                        state_d = S_IDLE;
                        err_inc = 1'b1;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_IDLE;
                    err_inc = 1'b1;
                end
            end
            S_PROC: begin
                state_d = S_IDLE;
                if (!cal_done_q) begin
                    if (cal_cnt_q == CAL_LAST) begin
                        bias_d     = 16'(acc_sum >>> CAL_LOG2);
                        cal_done_d = 1'b1;
                        acc_d      = '0;
                        cal_cnt_d  = '0;
                    end else begin
                        acc_d     = acc_sum;
                        cal_cnt_d = cal_cnt_q + 1'b1;
                    end
                end else begin
                    res_d     = diff_sat;
                    res_vld_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            idx_q        <= '0;
            byte0_q      <= '0;
            byte1_q      <= '0;
            acc_q        <= '0;
            cal_cnt_q    <= '0;
            bias_q       <= '0;
            cal_done_q   <= 1'b0;
            recal_pend_q <= 1'b0;
            rd_req_q     <= 1'b0;
            err_cnt_q    <= '0;
            ovr_cnt_q    <= '0;
            res_q        <= '0;
            res_vld_q    <= 1'b0;
            acc_out_q    <= '0;
            acc_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            idx_q        <= idx_d;
            byte0_q      <= byte0_d;
            byte1_q      <= byte1_d;
            acc_q        <= acc_d;
            cal_cnt_q    <= cal_cnt_d;
            bias_q       <= bias_d;
            cal_done_q   <= cal_done_d;
            recal_pend_q <= recal_pend_d;
            rd_req_q     <= rd_req_d;
            err_cnt_q    <= err_cnt_d;
            ovr_cnt_q    <= ovr_cnt_d;
            res_q        <= res_d;
            res_vld_q    <= res_vld_d;
            acc_out_q    <= acc_out_d;
            acc_valid_q  <= acc_valid_d;
        end
    end

    assign rd_req    = rd_req_q;
    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
    assign cal_done  = cal_done_q;
    assign err_cnt   = err_cnt_q;
    assign ovr_cnt   = ovr_cnt_q;

endmodule
